// File: rtl/pipe_div_defs.sv
// Shared definitions for the iterative divider sequencer.
// States, default width and divide-by-zero quotient.
package pipe_div_defs;

  localparam int DIV_WIDTH = 32;
  localparam logic [31:0] DIV_BYZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/pipe_div_if.sv
// EXE <-> divider handshake bundle.
// master = EXE side, slave = divider side.
interface pipe_div_if #(
  parameter int WIDTH = pipe_div_defs::DIV_WIDTH
);

  logic             start;
  logic             sign;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             w_hi;
  logic             w_lo;

  modport master (
    output start, sign, dividend, divisor, cancel,
    input  busy, stall, done, q, r, w_hi, w_lo
  );

  modport slave (
    input  start, sign, dividend, divisor, cancel,
    output busy, stall, done, q, r, w_hi, w_lo
  );

endinterface

// File: rtl/div_step.sv
// One restoring division iteration on {rem,quo}.
// An extra borrow bit keeps the shifted remainder exact.
module div_step
  import pipe_div_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  assign sh   = {rem, quo[WIDTH-1]};
  assign diff = sh - {1'b0, divisor};

  always_comb begin
    rem_nxt = sh[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/pipe_div_ctrl.sv
// Multi-cycle restoring DIV/DIVU sequencer beside EXE.
// Optional DIV_EARLY_EXIT_EN: skip iterations when |dividend| < |divisor|.
module pipe_div_ctrl
  import pipe_div_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input logic        clk,
  input logic        rst,
  pipe_div_if.slave  bus
);

  div_state_e state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] q, r;
  logic             q_neg, r_neg;
  logic             accept, by_zero, early, last;
  logic             a_neg, b_neg;

  assign a_neg   = bus.sign & bus.dividend[WIDTH-1];
  assign b_neg   = bus.sign & bus.divisor[WIDTH-1];
  assign abs_a   = a_neg ? -bus.dividend : bus.dividend;
  assign abs_b   = b_neg ? -bus.divisor : bus.divisor;
  assign accept  = (state == IDLE) & bus.start & ~bus.cancel;
  assign by_zero = (bus.divisor == '0);
  assign last    = (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_EARLY_EXIT_EN
  assign early = ~by_zero & (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvs),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_comb begin
    state_nxt = state;
    if (bus.cancel) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.start) state_nxt = (by_zero | early) ? DONE : RUN;
        RUN:     if (last) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      q     <= '0;
      r     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        quo   <= abs_a;
        dvs   <= abs_b;
        rem   <= '0;
        cnt   <= '0;
        q_neg <= a_neg ^ b_neg;
        r_neg <= a_neg;
        // short paths resolve here and go straight to DONE
        if (by_zero) begin
          q <= WIDTH'(DIV_BYZERO_Q);
          r <= bus.dividend;
        end else if (early) begin
          q <= '0;
          r <= bus.dividend;
        end
      end else if (state == RUN) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + CNT_W'(1);
      end else if (state == FIX && !bus.cancel) begin
        q <= q_neg ? -quo : quo;
        r <= r_neg ? -rem : rem;
      end
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.stall = (bus.busy & ~bus.done) | accept;
  assign bus.w_hi  = bus.done;
  assign bus.w_lo  = bus.done;
  assign bus.q     = q;
  assign bus.r     = r;

endmodule

// File: tb/tb_pipe_div_ctrl.sv
// Directed bench for pipe_div_ctrl with a cycle-level result model.
// Honors DIV_EARLY_EXIT_EN to pick the expected short-path latency.
module tb_pipe_div_ctrl;
  import pipe_div_defs::*;

`ifdef DIV_EARLY_EXIT_EN
  localparam int EL = 1;
`else
  localparam int EL = 34;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_div_if bus ();

  pipe_div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  bit          m_act = 1'b0;
  int          m_k   = 0;
  int          m_lat = 0;
  logic [31:0] m_q, m_r;
  logic [31:0] h_q = '0;
  logic [31:0] h_r = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Result and latency straight from the arithmetic definition
  function automatic void model_res(input logic [31:0] a, b,
                                    input logic s,
                                    output logic [31:0] qv, rv,
                                    output int lat);
    longint sa, sb, qq, rr, ma, mb;
    lat = 34;
    if (b == 0) begin
      qv = 32'hFFFF_FFFF;
      rv = a;
      lat = 1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      qv = qq[31:0];
      rv = rr[31:0];
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      if (ma < mb) lat = EL;
    end else begin
      qv = a / b;
      rv = a % b;
      if (a < b) lat = EL;
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_act = 1'b0;
      h_q = '0;
      h_r = '0;
    end else if (!m_act) begin
      if (bus.start && !bus.cancel) begin
        model_res(bus.dividend, bus.divisor, bus.sign, m_q, m_r, m_lat);
        m_act = 1'b1;
        m_k = 1;
        if (m_lat == 1) begin
          h_q = m_q;
          h_r = m_r;
        end
      end
    end else if (bus.cancel || m_k == m_lat) begin
      m_act = 1'b0;
    end else begin
      m_k++;
      if (m_k == m_lat) begin
        h_q = m_q;
        h_r = m_r;
      end
    end
  end

  initial forever begin
    logic e_done, e_stall;
    @(negedge clk);
    e_done  = m_act && (m_k == m_lat);
    e_stall = (m_act && !e_done) || (!m_act && bus.start && !bus.cancel);
    chk("busy",  32'(bus.busy),  32'(m_act));
    chk("done",  32'(bus.done),  32'(e_done));
    chk("w_hi",  32'(bus.w_hi),  32'(e_done));
    chk("w_lo",  32'(bus.w_lo),  32'(e_done));
    chk("stall", 32'(bus.stall), 32'(e_stall));
    chk("q",     bus.q, h_q);
    chk("r",     bus.r, h_r);
  end

  task automatic go(logic [31:0] a, logic [31:0] b, logic s);
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.start = 1'b1;
    bus.sign = s;
    bus.dividend = a;
    bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [31:0] qv, rv);
    lat = -1;
    qv = 'x;
    rv = 'x;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = cyc - t0;
        qv = bus.q;
        rv = bus.r;
        break;
      end
    end
  endtask

  task automatic run(string name, logic [31:0] a, logic [31:0] b, logic s,
                     logic [31:0] eq, logic [31:0] er, int el);
    int lat;
    logic [31:0] qv, rv;
    go(a, b, s);
    wait_done(lat, qv, rv);
    chk({name, "_lat"}, 32'(lat), 32'(el));
    chk({name, "_q"}, qv, eq);
    chk({name, "_r"}, rv, er);
  endtask

  initial begin
    int lat;
    logic [31:0] qv, rv;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.sign = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    bus.cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_q", bus.q, 32'd0);

    run("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34);
    run("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
        32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    run("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 34);
    run("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
        32'h8000_0000, 32'd0, 34);
    run("divu_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
        32'd0, 32'h8000_0000, EL);
    run("div_by0", 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1);

    go(32'd50, 32'd5, 1'b0);
    repeat (9) @(posedge clk);
    #1 bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    @(negedge clk);
    chk("cancel_busy", 32'(bus.busy), 32'd0);
    chk("cancel_q", bus.q, 32'hFFFF_FFFF);
    chk("cancel_r", bus.r, 32'h1234);
    run("after_cancel", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 34);

    go(32'd1000, 32'd3, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.dividend = 32'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.dividend = 32'd1000;
    wait_done(lat, qv, rv);
    chk("ignore_lat", 32'(lat), 32'd34);
    chk("ignore_q", qv, 32'd333);
    chk("ignore_r", rv, 32'd1);

    go(32'd77, 32'd4, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_q", bus.q, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run("divu_3_9", 32'd3, 32'd9, 1'b0, 32'd0, 32'd3, EL);
    run("div_m3_9", 32'hFFFF_FFFD, 32'd9, 1'b1, 32'd0, 32'hFFFF_FFFD, EL);
    run("divu_max", 32'hFFFF_FFFF, 32'd16, 1'b0, 32'h0FFF_FFFF, 32'd15, 34);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
